// File: rtl/io_terminal.sv
// io_terminal: keyboard/printer terminal for a simple accumulator CPU.
//
// Keyboard side: characters strobed in on kbd_strobe are queued in a
// FIFO_DEPTH-entry circular FIFO. The CPU sees the FIFO head through inpr
// while fgi is set and pops it with cpu_inp.
//
// Printer side: a three-state machine (idle / send / recover) takes one
// character per cpu_out, presents it on a valid/ready handshake, then waits
// RECOVERY cycles before raising fgo again.
//
// Interrupts: ien is set/cleared by cpu_ion/cpu_iof; irq requests service
// whenever either flag is up and interrupts are enabled.
//
// Ports
//   clock       in   single clock, rising edge
//   reset       in   synchronous, active-high
//   kbd_data    in   [7:0] keyboard character
//   kbd_strobe  in   one-cycle pulse, push kbd_data
//   inpr        out  [7:0] FIFO head when fgi=1, else 8'h00
//   fgi         out  FIFO non-empty
//   cpu_inp     in   one-cycle pulse, pop FIFO head (ignored when empty)
//   outr_data   in   [7:0] character to print, sampled with cpu_out
//   cpu_out     in   one-cycle pulse, start printing outr_data
//   fgo         out  printer side ready for a new character
//   prt_data    out  [7:0] character presented to the printer
//   prt_valid   out  printer handshake valid
//   prt_ready   in   printer handshake ready
//   cpu_ion     in   one-cycle pulse, set ien
//   cpu_iof     in   one-cycle pulse, clear ien (wins over cpu_ion)
//   ien         out  interrupt enable
//   irq         out  ien & (fgi | fgo)
//   err_ovf     out  sticky: keyboard character dropped on full FIFO
//   err_col     out  sticky: cpu_out while the printer side was busy

module io_terminal #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RECOVERY   = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] kbd_data,
  input  logic       kbd_strobe,
  output logic [7:0] inpr,
  output logic       fgi,
  input  logic       cpu_inp,
  input  logic [7:0] outr_data,
  input  logic       cpu_out,
  output logic       fgo,
  output logic [7:0] prt_data,
  output logic       prt_valid,
  input  logic       prt_ready,
  input  logic       cpu_ion,
  input  logic       cpu_iof,
  output logic       ien,
  output logic       irq,
  output logic       err_ovf,
  output logic       err_col
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned RecW = $clog2(RECOVERY + 1);

  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);
  localparam logic [RecW-1:0] RecLoad = RecW'(RECOVERY - 1);

  // ---------------------------------------------------------------------------
  // Keyboard FIFO
  // ---------------------------------------------------------------------------

  logic [7:0]      fifoMem [FIFO_DEPTH];
  logic [PtrW-1:0] wrPtrQ, wrPtrD;
  logic [PtrW-1:0] rdPtrQ, rdPtrD;
  logic [CntW-1:0] countQ, countD;
  logic            errOvfQ, errOvfD;

  logic fifoFull;
  logic fifoNonEmpty;
  logic popEn;
  logic pushEn;

  assign fifoFull     = (countQ == FullCnt);
  assign fifoNonEmpty = (countQ != '0);

  // A pop on an empty FIFO is a no-op; a pop in the same cycle as a push
  // frees the slot the push needs, so a full FIFO still accepts the push.
  assign popEn  = cpu_inp && fifoNonEmpty;
  assign pushEn = kbd_strobe && (!fifoFull || popEn);

  always_comb begin
    wrPtrD  = wrPtrQ;
    rdPtrD  = rdPtrQ;
    countD  = countQ;
    errOvfD = errOvfQ;

    if (pushEn) begin
      wrPtrD = wrPtrQ + PtrW'(1);
    end
    if (popEn) begin
      rdPtrD = rdPtrQ + PtrW'(1);
    end

    unique case ({pushEn, popEn})
      2'b10:   countD = countQ + CntW'(1);
      2'b01:   countD = countQ - CntW'(1);
      default: countD = countQ;
    endcase

    if (kbd_strobe && !pushEn) begin
      errOvfD = 1'b1;
    end
  end

  // Storage needs no reset: the empty count masks stale entries.
  always_ff @(posedge clock) begin
    if (!reset && pushEn) begin
      fifoMem[wrPtrQ] <= kbd_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtrQ  <= '0;
      rdPtrQ  <= '0;
      countQ  <= '0;
      errOvfQ <= 1'b0;
    end else begin
      wrPtrQ  <= wrPtrD;
      rdPtrQ  <= rdPtrD;
      countQ  <= countD;
      errOvfQ <= errOvfD;
    end
  end

  assign fgi     = fifoNonEmpty;
  assign inpr    = fifoNonEmpty ? fifoMem[rdPtrQ] : 8'h00;
  assign err_ovf = errOvfQ;

  // ---------------------------------------------------------------------------
  // Printer output state machine
  // ---------------------------------------------------------------------------

  typedef enum logic [1:0] {
    OIdle  = 2'd0,
    OSend  = 2'd1,
    ORecov = 2'd2
  } outState_t;

  outState_t       outStateQ, outStateD;
  logic [RecW-1:0] recCntQ, recCntD;
  logic [7:0]      prtDataQ, prtDataD;
  logic            errColQ, errColD;

  always_comb begin
    outStateD = outStateQ;
    recCntD   = recCntQ;
    prtDataD  = prtDataQ;
    errColD   = errColQ;
    fgo       = 1'b0;
    prt_valid = 1'b0;

    unique case (outStateQ)
      OIdle: begin
        fgo = 1'b1;
        if (cpu_out) begin
          prtDataD  = outr_data;
          outStateD = OSend;
        end
      end
      OSend: begin
        prt_valid = 1'b1;
        if (prt_ready) begin
          outStateD = ORecov;
          recCntD   = RecLoad;
        end
      end
      ORecov: begin
        // Counter starts at RECOVERY-1, so this state lasts RECOVERY cycles.
        if (recCntQ == '0) begin
          outStateD = OIdle;
        end else begin
          recCntD = recCntQ - RecW'(1);
        end
      end
      default: begin
        outStateD = OIdle;
      end
    endcase

    // Busy-time OUT is dropped; the character already in flight stays put.
    if (cpu_out && (outStateQ != OIdle)) begin
      errColD = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      outStateQ <= OIdle;
      recCntQ   <= '0;
      prtDataQ  <= 8'h00;
      errColQ   <= 1'b0;
    end else begin
      outStateQ <= outStateD;
      recCntQ   <= recCntD;
      prtDataQ  <= prtDataD;
      errColQ   <= errColD;
    end
  end

  assign prt_data = prtDataQ;
  assign err_col  = errColQ;

  // ---------------------------------------------------------------------------
  // Interrupt enable and request
  // ---------------------------------------------------------------------------

  logic ienQ, ienD;

  always_comb begin
    ienD = ienQ;
    if (cpu_iof) begin
      ienD = 1'b0;
    end else if (cpu_ion) begin
      ienD = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ienQ <= 1'b0;
    end else begin
      ienQ <= ienD;
    end
  end

  assign ien = ienQ;
  // Both terms come straight from registers, so irq has no input-to-output path.
  assign irq = ienQ && (fifoNonEmpty || (outStateQ == OIdle));

endmodule

// File: tb/tb_io_terminal.sv
// Self-checking bench for io_terminal: directed scenarios followed by a
// randomized run, all compared every cycle against a queue-based model.

module tb_io_terminal;

  localparam int Depth = 4;
  localparam int Recov = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] kbd_data;
  logic       kbd_strobe;
  logic [7:0] inpr;
  logic       fgi;
  logic       cpu_inp;
  logic [7:0] outr_data;
  logic       cpu_out;
  logic       fgo;
  logic [7:0] prt_data;
  logic       prt_valid;
  logic       prt_ready;
  logic       cpu_ion;
  logic       cpu_iof;
  logic       ien;
  logic       irq;
  logic       err_ovf;
  logic       err_col;

  io_terminal #(
    .FIFO_DEPTH(Depth),
    .RECOVERY  (Recov)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .kbd_data  (kbd_data),
    .kbd_strobe(kbd_strobe),
    .inpr      (inpr),
    .fgi       (fgi),
    .cpu_inp   (cpu_inp),
    .outr_data (outr_data),
    .cpu_out   (cpu_out),
    .fgo       (fgo),
    .prt_data  (prt_data),
    .prt_valid (prt_valid),
    .prt_ready (prt_ready),
    .cpu_ion   (cpu_ion),
    .cpu_iof   (cpu_iof),
    .ien       (ien),
    .irq       (irq),
    .err_ovf   (err_ovf),
    .err_col   (err_col)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: character queue, flags, and printer as "char pending"
  // plus "recovery cycles still to wait".
  logic [7:0] mQ[$];
  bit         mIen, mOvf, mCol, mSend;
  int         mRecLeft;
  logic [7:0] mPrt;

  function automatic bit mFgo();
    return !mSend && (mRecLeft == 0);
  endfunction

  task automatic modelStep();
    bit idle;
    if (reset) begin
      mQ.delete();
      mIen = 0; mOvf = 0; mCol = 0; mSend = 0; mRecLeft = 0; mPrt = 8'h00;
      return;
    end
    if (cpu_inp && mQ.size() != 0) void'(mQ.pop_front());
    if (kbd_strobe) begin
      if (mQ.size() < Depth) mQ.push_back(kbd_data);
      else mOvf = 1;
    end
    if (cpu_iof) mIen = 0;
    else if (cpu_ion) mIen = 1;
    idle = mFgo();
    if (mSend) begin
      if (prt_ready) begin
        mSend = 0;
        mRecLeft = Recov;
      end
    end else if (mRecLeft > 0) begin
      mRecLeft--;
    end
    if (cpu_out) begin
      if (idle) begin
        mSend = 1;
        mPrt = outr_data;
      end else begin
        mCol = 1;
      end
    end
  endtask

  task automatic compareAll();
    bit eFgi;
    eFgi = (mQ.size() != 0);
    checkVal("fgi", fgi, eFgi);
    checkVal("inpr", inpr, eFgi ? mQ[0] : 8'h00);
    checkVal("fgo", fgo, mFgo());
    checkVal("prt_valid", prt_valid, mSend);
    checkVal("prt_data", prt_data, mPrt);
    checkVal("ien", ien, mIen);
    checkVal("irq", irq, mIen && (eFgi || mFgo()));
    checkVal("err_ovf", err_ovf, mOvf);
    checkVal("err_col", err_col, mCol);
  endtask

  // One clock: model consumes the inputs seen at the edge, outputs checked
  // 1 time unit later, then single-cycle pulses are dropped.
  task automatic tick();
    @(posedge clock);
    modelStep();
    #1;
    compareAll();
    kbd_strobe = 0;
    cpu_inp    = 0;
    cpu_out    = 0;
    cpu_ion    = 0;
    cpu_iof    = 0;
  endtask

  task automatic push(input logic [7:0] d);
    kbd_strobe = 1;
    kbd_data   = d;
    tick();
  endtask

  task automatic pop();
    cpu_inp = 1;
    tick();
  endtask

  task automatic doReset();
    reset = 1;
    tick();
    reset = 0;
  endtask

  initial begin
    int validCycles;
    int waitCycles;
    reset = 1; kbd_data = 0; kbd_strobe = 0; cpu_inp = 0; outr_data = 0;
    cpu_out = 0; prt_ready = 0; cpu_ion = 0; cpu_iof = 0;
    tick();
    doReset();

    // Post-reset outputs.
    checkVal("rst_inpr", inpr, 8'h00);
    checkVal("rst_fgi", fgi, 0);
    checkVal("rst_fgo", fgo, 1);
    checkVal("rst_prt_valid", prt_valid, 0);
    checkVal("rst_irq", irq, 0);

    // Single character in and out.
    push(8'h41);
    checkVal("k41_fgi", fgi, 1);
    checkVal("k41_inpr", inpr, 8'h41);
    pop();
    checkVal("k41_pop_fgi", fgi, 0);
    checkVal("k41_pop_inpr", inpr, 8'h00);
    pop();  // pop on empty: ignored

    // Overflow: fifth push dropped.
    for (int i = 1; i <= 5; i++) push(8'(i));
    checkVal("ovf_set", err_ovf, 1);
    for (int i = 1; i <= 4; i++) begin
      checkVal("ovf_pop_order", inpr, 32'(i));
      pop();
    end
    checkVal("ovf_drained", fgi, 0);

    // Full FIFO with simultaneous push and pop.
    doReset();
    for (int i = 1; i <= 4; i++) push(8'(i));
    kbd_strobe = 1; kbd_data = 8'h09; cpu_inp = 1;
    tick();
    checkVal("pp_no_ovf", err_ovf, 0);
    checkVal("pp_count", mQ.size(), 4);
    begin
      logic [7:0] expSeq [4];
      expSeq = '{8'h02, 8'h03, 8'h04, 8'h09};
      for (int i = 0; i < 4; i++) begin
        checkVal("pp_pop_order", inpr, expSeq[i]);
        pop();
      end
    end

    // Printer handshake with a slow printer, then collision in recovery.
    outr_data = 8'h55; cpu_out = 1; prt_ready = 0;
    tick();
    validCycles = 0;
    for (int i = 0; i < 3; i++) begin
      if (prt_valid && prt_data == 8'h55) validCycles++;
      tick();
    end
    prt_ready = 1;
    if (prt_valid && prt_data == 8'h55) validCycles++;
    tick();
    prt_ready = 0;
    checkVal("prt_valid_len", validCycles, 4);
    // Now one cycle after the handshake, in recovery.
    outr_data = 8'hAA; cpu_out = 1;
    tick();
    checkVal("col_set", err_col, 1);
    checkVal("col_prt_hold", prt_data, 8'h55);
    waitCycles = 2;
    while (!fgo && waitCycles < 20) begin
      tick();
      waitCycles++;
    end
    checkVal("fgo_return", waitCycles, Recov + 1);

    // Turnaround with prt_ready held high.
    prt_ready = 1; outr_data = 8'h33; cpu_out = 1;
    tick();
    waitCycles = 1;
    while (!fgo && waitCycles < 20) begin
      tick();
      waitCycles++;
    end
    checkVal("turnaround", waitCycles, Recov + 2);
    prt_ready = 0;

    // Interrupt enable.
    cpu_ion = 1;
    tick();
    checkVal("ion_irq", irq, 1);
    cpu_ion = 1; cpu_iof = 1;
    tick();
    checkVal("ioniof_ien", ien, 0);
    checkVal("ioniof_irq", irq, 0);

    // Reset while sending with three characters queued.
    for (int i = 0; i < 3; i++) push(8'h70 + 8'(i));
    cpu_ion = 1; outr_data = 8'h66; cpu_out = 1;
    tick();
    cpu_out = 1;  // collision while in send
    push(8'h73);
    push(8'h74);  // overflow
    checkVal("pre_rst_valid", prt_valid, 1);
    checkVal("pre_rst_ovf", err_ovf, 1);
    doReset();
    checkVal("send_rst_valid", prt_valid, 0);
    checkVal("send_rst_fgi", fgi, 0);
    checkVal("send_rst_fgo", fgo, 1);
    checkVal("send_rst_flags", {ien, err_ovf, err_col}, 3'b000);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 199) == 0);
      kbd_strobe = ($urandom_range(0, 9) < 4);
      kbd_data   = 8'($urandom);
      cpu_inp    = ($urandom_range(0, 9) < 3);
      cpu_out    = ($urandom_range(0, 9) < 2);
      outr_data  = 8'($urandom);
      prt_ready  = ($urandom_range(0, 1) == 1);
      cpu_ion    = ($urandom_range(0, 19) == 0);
      cpu_iof    = ($urandom_range(0, 19) == 0);
      tick();
    end
    reset = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/io_terminal.md
IO_TERMINAL -- requirements
Module: io_terminal

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, keyboard input FIFO entries, power of two, at least 2.
REQ-002 Parameter RECOVERY, default 2, printer recovery cycles after each accepted byte, at least 1.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 kbd_data  input  8  keyboard character, sampled when kbd_strobe=1.
REQ-006 kbd_strobe  input  1  one-cycle pulse, one character arrives.
REQ-007 inpr  output  8  CPU input register view: FIFO head when fgi=1, else 8'h00.
REQ-008 fgi  output  1  input flag: FIFO non-empty.
REQ-009 cpu_inp  input  1  one-cycle pulse, CPU executed INP and consumed inpr.
REQ-010 outr_data  input  8  CPU output register, sampled when cpu_out=1.
REQ-011 cpu_out  input  1  one-cycle pulse, CPU executed OUT.
REQ-012 fgo  output  1  output flag: device ready for a new character.
REQ-013 prt_data  output  8  character presented to the printer.
REQ-014 prt_valid  output  1  printer handshake valid.
REQ-015 prt_ready  input  1  printer handshake ready.
REQ-016 cpu_ion / cpu_iof  input  1 each  one-cycle pulses, ION / IOF instruction or interrupt-cycle entry.
REQ-017 ien  output  1  interrupt enable flip-flop.
REQ-018 irq  output  1  interrupt request to CPU.
REQ-019 err_ovf / err_col  output  1 each  sticky: keyboard overflow / OUT while busy.

Function
REQ-020 The keyboard side SHALL be a FIFO_DEPTH-entry circular FIFO with wrap-around read/write pointers and an occupancy count.
REQ-021 kbd_strobe SHALL push kbd_data; fgi and inpr SHALL reflect the push on the next cycle (1-cycle latency).
REQ-022 cpu_inp with fgi=1 SHALL pop the head; cpu_inp with fgi=0 SHALL be ignored, state unchanged.
REQ-023 Push into a full FIFO without a simultaneous pop SHALL drop the character and set err_ovf.
REQ-024 Simultaneous push and pop SHALL both take effect, count unchanged, including when full; no overflow.
REQ-025 The output side SHALL be a state machine: O_IDLE, O_SEND, O_RECOV.
REQ-026 O_IDLE: fgo=1, prt_valid=0; cpu_out latches outr_data into prt_data and moves to O_SEND.
REQ-027 O_SEND: fgo=0, prt_valid=1, prt_data held stable; prt_ready=1 moves to O_RECOV with the counter loaded to RECOVERY-1.
REQ-028 O_RECOV: fgo=0, prt_valid=0; counter decrements each cycle; at 0 the FSM moves to O_IDLE, fgo=1 next cycle.
REQ-029 cpu_out in O_SEND or O_RECOV SHALL be ignored (prt_data unchanged) and set err_col.
REQ-030 Minimum cpu_out-to-fgo=1 turnaround with prt_ready held high SHALL be RECOVERY+2 cycles.
REQ-031 cpu_ion SHALL set ien, cpu_iof SHALL clear ien; both in one cycle -> ien=0.
REQ-032 irq SHALL equal ien AND (fgi OR fgo), combinational from registered state only.
REQ-033 err_ovf and err_col SHALL clear only on reset.

Reset
REQ-034 reset=1 at a rising edge SHALL have priority over all inputs and SHALL empty the FIFO, zero the pointers, count and prt_data, force O_IDLE, and clear ien, err_ovf and err_col.
REQ-035 Post-reset outputs: inpr=8'h00, fgi=0, fgo=1, prt_valid=0, ien=0, irq=0.
REQ-036 Reset during O_SEND SHALL drop prt_valid on the next cycle and discard the character.

Verification
REQ-037 Reset, then kbd_strobe with 8'h41 -> next cycle fgi=1, inpr=8'h41; cpu_inp -> next cycle fgi=0, inpr=8'h00.
REQ-038 Push 8'h01..8'h05 with no pops -> err_ovf=1, FIFO holds 01..04; four pops return 01,02,03,04 in order.
REQ-039 FIFO full, push 8'h09 together with cpu_inp -> err_ovf stays 0, count stays 4, later pops return 02,03,04,09.
REQ-040 cpu_out with 8'h55, prt_ready low 3 cycles then high -> prt_valid held 3+1 cycles with prt_data=8'h55; fgo returns RECOVERY+1 cycles after the handshake; a second cpu_out during O_RECOV sets err_col.
REQ-041 cpu_ion, FIFO empty, fgo=1 -> irq=1; cpu_ion+cpu_iof same cycle -> ien=0, irq=0.
REQ-042 Reset asserted in O_SEND with a FIFO of 3 entries -> next cycle prt_valid=0, fgi=0, fgo=1, all flags 0.
